pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipelined MIPS core; sits beside the forwarding logic and drives the freeze, bubble and flush controls of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Resolves three event types:
  - load-use and RAW data hazards, which depend on the forwarding mode;
  - multi-cycle SRAM accesses from the MEM stage, with a watchdog timeout;
  - taken-branch flushes from the EXE stage.

Parameters:
- MEM_TIMEOUT, 64, maximum number of MEM_WAIT cycles before mem_error asserts; must be at least 2.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- forward_enable  in  1  forwarding unit active
- id_src1  in  5  ID-stage source register 1
- id_src2  in  5  ID-stage source register 2
- id_two_src  in  1  ID instruction reads src2 (R-type or store)
- exe_dest  in  5  EXE-stage destination register
- exe_wb  in  1  EXE instruction writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  5  MEM-stage destination register
- mem_wb  in  1  MEM instruction writes back
- mem_req  in  1  MEM stage starts an SRAM access this cycle
- sram_ready  in  1  SRAM access complete
- branch_taken  in  1  EXE-stage branch resolved as taken
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- bubble_id_exe  out  1  load a NOP into ID/EXE
- flush_if_id  out  1  clear IF/ID register
- freeze_back  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
- mem_error  out  1  sticky SRAM timeout flag
- busy  out  1  state is not RUN

Behaviour:
- Reset: state is RUN, the wait counter is 0, mem_error is 0, and every output is 0.
- Source match, per source s (src2 counts only when id_two_src=1):
  - match_exe(s) = s≠0 && s==exe_dest && exe_wb
  - match_mem(s) = s≠0 && s==mem_dest && mem_wb
- Data hazard (combinational):
  - forward_enable=1: hazard = exe_mem_read && match_exe.
  - forward_enable=0: hazard = match_exe || match_mem.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when mem_req=1 and sram_ready=0.
  - A request with sram_ready=1 in the same cycle completes with zero wait and the FSM stays in RUN.
  - MEM_WAIT -> RUN on the first cycle sram_ready=1. freeze_back and freeze_pc stay asserted through that cycle and release on the next.
  - MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT−1 with no ready. Entering ERROR sets mem_error.
  - ERROR holds every freeze output until rst. mem_error stays sticky until rst.
  - The wait counter clears on entry to MEM_WAIT and increments once per MEM_WAIT cycle.
- Output priority, highest first:
  1. MEM_WAIT/ERROR, or RUN with mem_req && !sram_ready: freeze_pc=freeze_if_id=freeze_back=1, bubble=0, flush=0. The pipeline is frozen, so branch_taken and the hazard inputs stay stable and are re-evaluated after release; no pending flags are kept.
  2. branch_taken: flush_if_id=1 and bubble_id_exe=1 for that cycle; the PC loads the target, so freeze_pc=0. This masks any data hazard from the wrong-path instruction.
  3. hazard: freeze_pc=1, freeze_if_id=1, bubble_id_exe=1.
  4. Otherwise all outputs are 0.
- Latency:
  - hazard and branch responses are combinational within the same cycle;
  - the MEM freeze asserts in the same cycle as mem_req;
  - busy is registered and reflects the state.
- A load-use stall lasts exactly 1 cycle with forwarding and up to 2 cycles without.
- rst asserted during MEM_WAIT or ERROR returns to RUN on the next edge and drops every output.

Optional Feature:
- Macro: STALL_PERF_COUNTERS_EN.
- Defined: adds output ports data_stall_cnt, branch_flush_cnt and mem_wait_cnt, each CNT_W bits.
  - Each counter increments by 1 per cycle in which its priority level is the active one.
  - Counters saturate at all-ones and clear on rst.
- Undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the constant REG_ZERO=5'd0;
  - the register-index width 5.
- Sub-module hazard_detect: the combinational source/destination match and hazard equation. It is instantiated once, and the FSM plus output priority stay in the top level.

Test Plan:
- Load-use with forwarding: forward_enable=1, exe_mem_read=1, exe_dest=5, exe_wb=1, id_src1=5 -> freeze_pc=freeze_if_id=bubble_id_exe=1 for 1 cycle; id_src1=0 with exe_dest=0 -> no stall.
- No forwarding: forward_enable=0, mem_dest=7, mem_wb=1, id_two_src=1, id_src2=7 -> stall asserted; the same stimulus with id_two_src=0 -> no stall.
- Branch over hazard: branch_taken=1 together with an active hazard -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0.
- SRAM wait: mem_req=1 and sram_ready=0 for 3 cycles, then 1 -> freeze_back=1 for 4 cycles, busy=1 from the cycle after the request through the ready cycle, then all outputs 0; mem_req with sram_ready=1 in the same cycle -> no freeze.
- Timeout: MEM_TIMEOUT=4 and sram_ready held low -> mem_error=1 after the 4th wait cycle, freezes held; rst=1 clears everything on the next edge.
- Branch pending during a MEM freeze: branch_taken=1 during MEM_WAIT -> no flush until release, then flush_if_id=1 in the first RUN cycle.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrlState_e;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/SRAM/branch inputs and pipeline control outputs of the stall controller.
interface pipeline_stall_controller_if;
    import mips_ctrl_pkg::*;

    logic             forward_enable;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb;
    logic             mem_req;
    logic             sram_ready;
    logic             branch_taken;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             freeze_back;
    logic             mem_error;
    logic             busy;

    // The pipeline side drives events and consumes the controls.
    modport master (
        output forward_enable, id_src1, id_src2, id_two_src,
               exe_dest, exe_wb, exe_mem_read, mem_dest, mem_wb,
               mem_req, sram_ready, branch_taken,
        input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id,
               freeze_back, mem_error, busy
    );

    modport slave (
        input  forward_enable, id_src1, id_src2, id_two_src,
               exe_dest, exe_wb, exe_mem_read, mem_dest, mem_wb,
               mem_req, sram_ready, branch_taken,
        output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id,
               freeze_back, mem_error, busy
    );

endinterface

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// Combinational RAW / load-use hazard detection for the ID-stage sources.
module hazard_detect
    import mips_ctrl_pkg::*;
(
    input  logic             i_forwardEnable,
    input  logic [REG_W-1:0] i_idSrc1,
    input  logic [REG_W-1:0] i_idSrc2,
    input  logic             i_idTwoSrc,
    input  logic [REG_W-1:0] i_exeDest,
    input  logic             i_exeWb,
    input  logic             i_exeMemRead,
    input  logic [REG_W-1:0] i_memDest,
    input  logic             i_memWb,
    output logic             o_hazard
);

    logic w_src1Exe;
    logic w_src2Exe;
    logic w_src1Mem;
    logic w_src2Mem;
    logic w_matchExe;
    logic w_matchMem;

    // Register zero never carries a dependency; src2 only matters for two-source instructions.
    assign w_src1Exe = (i_idSrc1 != REG_ZERO) && (i_idSrc1 == i_exeDest) && i_exeWb;
    assign w_src2Exe = i_idTwoSrc && (i_idSrc2 != REG_ZERO) && (i_idSrc2 == i_exeDest) && i_exeWb;
    assign w_src1Mem = (i_idSrc1 != REG_ZERO) && (i_idSrc1 == i_memDest) && i_memWb;
    assign w_src2Mem = i_idTwoSrc && (i_idSrc2 != REG_ZERO) && (i_idSrc2 == i_memDest) && i_memWb;

    assign w_matchExe = w_src1Exe || w_src2Exe;
    assign w_matchMem = w_src1Mem || w_src2Mem;

    // With forwarding only a load result in EXE is unavailable in time.
    assign o_hazard = i_forwardEnable ? (i_exeMemRead && w_matchExe)
                                      : (w_matchExe || w_matchMem);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline; STALL_PERF_COUNTERS_EN adds event counters.
module pipeline_stall_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef STALL_PERF_COUNTERS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    pipeline_stall_controller_if.slave bus
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] data_stall_cnt,
    output logic [CNT_W-1:0] branch_flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrlState_e        r_state;
    ctrlState_e        w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memError;
    logic              r_busy;
    logic              w_hazard;
    logic              w_memFreeze;
    logic              w_branchLevel;
    logic              w_hazardLevel;
    logic              w_freezePc;
    logic              w_freezeIfId;
    logic              w_bubble;
    logic              w_flush;
    logic              w_freezeBack;

    hazard_detect u_hazardDetect (
        .i_forwardEnable (bus.forward_enable),
        .i_idSrc1        (bus.id_src1),
        .i_idSrc2        (bus.id_src2),
        .i_idTwoSrc      (bus.id_two_src),
        .i_exeDest       (bus.exe_dest),
        .i_exeWb         (bus.exe_wb),
        .i_exeMemRead    (bus.exe_mem_read),
        .i_memDest       (bus.mem_dest),
        .i_memWb         (bus.mem_wb),
        .o_hazard        (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_waitCnt  <= '0;
            r_memError <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState != RUN);
            if (w_nextState == ERROR) begin
                r_memError <= 1'b1;
            end
            if (r_state == RUN) begin
                r_waitCnt <= '0;
            end else if (r_state == MEM_WAIT && w_nextState == MEM_WAIT) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
        end
    end

    // A frozen pipeline keeps branch/hazard inputs stable, so nothing needs to be remembered.
    always_comb begin
        w_nextState   = r_state;
        w_freezePc    = 1'b0;
        w_freezeIfId  = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_freezeBack  = 1'b0;
        w_branchLevel = 1'b0;
        w_hazardLevel = 1'b0;

        unique case (r_state)
            RUN: begin
                if (bus.mem_req && !bus.sram_ready) begin
                    w_nextState = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.sram_ready) begin
                    w_nextState = RUN;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = ERROR;
                end
            end
            ERROR: begin
                w_nextState = ERROR;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase

        w_memFreeze = (r_state != RUN) || (bus.mem_req && !bus.sram_ready);

        if (w_memFreeze) begin
            w_freezePc   = 1'b1;
            w_freezeIfId = 1'b1;
            w_freezeBack = 1'b1;
        end else if (bus.branch_taken) begin
            w_branchLevel = 1'b1;
            w_flush       = 1'b1;
            w_bubble      = 1'b1;
        end else if (w_hazard) begin
            w_hazardLevel = 1'b1;
            w_freezePc    = 1'b1;
            w_freezeIfId  = 1'b1;
            w_bubble      = 1'b1;
        end
    end

    assign bus.freeze_pc     = w_freezePc;
    assign bus.freeze_if_id  = w_freezeIfId;
    assign bus.bubble_id_exe = w_bubble;
    assign bus.flush_if_id   = w_flush;
    assign bus.freeze_back   = w_freezeBack;
    assign bus.mem_error     = r_memError;
    assign bus.busy          = r_busy;

`ifdef STALL_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_dataStallCnt;
    logic [CNT_W-1:0] r_branchFlushCnt;
    logic [CNT_W-1:0] r_memWaitCnt;

    // Each counter tracks cycles spent at its priority level and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataStallCnt   <= '0;
            r_branchFlushCnt <= '0;
            r_memWaitCnt     <= '0;
        end else begin
            if (w_hazardLevel && r_dataStallCnt != '1) begin
                r_dataStallCnt <= r_dataStallCnt + CNT_W'(1);
            end
            if (w_branchLevel && r_branchFlushCnt != '1) begin
                r_branchFlushCnt <= r_branchFlushCnt + CNT_W'(1);
            end
            if (w_memFreeze && r_memWaitCnt != '1) begin
                r_memWaitCnt <= r_memWaitCnt + CNT_W'(1);
            end
        end
    end

    assign data_stall_cnt   = r_dataStallCnt;
    assign branch_flush_cnt = r_branchFlushCnt;
    assign mem_wait_cnt     = r_memWaitCnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller built with MEM_TIMEOUT=4.
module tb_pipeline_stall_controller;

    typedef struct packed {
        logic       rst;
        logic       fwd;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       two;
        logic [4:0] exeDest;
        logic       exeWb;
        logic       exeMemRead;
        logic [4:0] memDest;
        logic       memWb;
        logic       memReq;
        logic       ready;
        logic       branch;
    } stim_t;

    // Expected vector order: freeze_pc, freeze_if_id, bubble, flush, freeze_back, mem_error, busy.
    localparam logic [6:0] E_IDLE  = 7'b000_0_0_0_0;
    localparam logic [6:0] E_STALL = 7'b111_0_0_0_0;
    localparam logic [6:0] E_FLUSH = 7'b001_1_0_0_0;
    localparam logic [6:0] E_MEMR  = 7'b110_0_1_0_0;
    localparam logic [6:0] E_MEMB  = 7'b110_0_1_0_1;
    localparam logic [6:0] E_ERR   = 7'b110_0_1_1_1;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    string      tagQ[$];
    logic [6:0] expQ[$];

    pipeline_stall_controller_if bus();

`ifdef STALL_PERF_COUNTERS_EN
    logic [15:0] dataStallCnt;
    logic [15:0] branchFlushCnt;
    logic [15:0] memWaitCnt;
`endif

    pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STALL_PERF_COUNTERS_EN
        ,
        .data_stall_cnt   (dataStallCnt),
        .branch_flush_cnt (branchFlushCnt),
        .mem_wait_cnt     (memWaitCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0b expected %0b", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus and queues what the outputs must look like in that cycle.
    task automatic applyStimulus(input string tag, input stim_t s, input logic [6:0] exp);
        rst                = s.rst;
        bus.forward_enable = s.fwd;
        bus.id_src1        = s.src1;
        bus.id_src2        = s.src2;
        bus.id_two_src     = s.two;
        bus.exe_dest       = s.exeDest;
        bus.exe_wb         = s.exeWb;
        bus.exe_mem_read   = s.exeMemRead;
        bus.mem_dest       = s.memDest;
        bus.mem_wb         = s.memWb;
        bus.mem_req        = s.memReq;
        bus.sram_ready     = s.ready;
        bus.branch_taken   = s.branch;
        tagQ.push_back(tag);
        expQ.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput(tagQ.pop_front(),
                        32'({bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe, bus.flush_if_id,
                             bus.freeze_back, bus.mem_error, bus.busy}),
                        32'(expQ.pop_front()));
        end
    end

    initial begin
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        rst = 1'b1;
        bus.forward_enable = 1'b0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_src = 1'b0;
        bus.exe_dest = '0; bus.exe_wb = 1'b0; bus.exe_mem_read = 1'b0; bus.mem_dest = '0;
        bus.mem_wb = 1'b0; bus.mem_req = 1'b0; bus.sram_ready = 1'b0; bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        s = '0;
        applyStimulus("reset", s, E_IDLE);

        // Load-use with forwarding stalls one cycle, then the load has moved to MEM.
        s = '0; s.fwd = 1; s.exeMemRead = 1; s.exeDest = 5; s.exeWb = 1; s.src1 = 5;
        applyStimulus("loadUseFwd", s, E_STALL);
        s = '0; s.fwd = 1; s.src1 = 5; s.memDest = 5; s.memWb = 1;
        applyStimulus("loadUseFwdRelease", s, E_IDLE);
        s = '0; s.fwd = 1; s.exeMemRead = 1; s.exeDest = 0; s.exeWb = 1; s.src1 = 0;
        applyStimulus("zeroReg", s, E_IDLE);

        s = '0; s.memDest = 7; s.memWb = 1; s.two = 1; s.src2 = 7;
        applyStimulus("noFwdMemSrc2", s, E_STALL);
        s.two = 0;
        applyStimulus("noFwdSrc2Unused", s, E_IDLE);
        s = '0; s.exeDest = 3; s.exeWb = 1; s.src1 = 3;
        applyStimulus("noFwdExeAlu", s, E_STALL);
        s.fwd = 1;
        applyStimulus("fwdExeAlu", s, E_IDLE);
        s.fwd = 0; s.exeWb = 0;
        applyStimulus("noFwdNoWb", s, E_IDLE);

        s = '0; s.fwd = 1; s.exeMemRead = 1; s.exeDest = 5; s.exeWb = 1; s.src1 = 5; s.branch = 1;
        applyStimulus("branchOverHazard", s, E_FLUSH);
        s = '0; s.branch = 1;
        applyStimulus("branchOnly", s, E_FLUSH);

        s = '0; s.memReq = 1; s.ready = 1;
        applyStimulus("sramZeroWait", s, E_IDLE);
        s = '0;
        applyStimulus("sramZeroWaitAfter", s, E_IDLE);

        // Three not-ready cycles then ready: four frozen cycles, busy from the second.
        s = '0; s.memReq = 1;
        applyStimulus("sramReq", s, E_MEMR);
        applyStimulus("sramWait1", s, E_MEMB);
        applyStimulus("sramWait2", s, E_MEMB);
        s.ready = 1;
        applyStimulus("sramReady", s, E_MEMB);
        s = '0;
        applyStimulus("sramReleased", s, E_IDLE);

        // A branch raised during the wait must not flush until the pipeline is released.
        s = '0; s.memReq = 1;
        applyStimulus("brReq", s, E_MEMR);
        s.branch = 1;
        applyStimulus("brWait1", s, E_MEMB);
        applyStimulus("brWait2", s, E_MEMB);
        s.ready = 1;
        applyStimulus("brReady", s, E_MEMB);
        s = '0; s.branch = 1;
        applyStimulus("brAfterRelease", s, E_FLUSH);

        // Reset while waiting drops back to RUN on the next edge.
        s = '0; s.memReq = 1;
        applyStimulus("rstWaitReq", s, E_MEMR);
        applyStimulus("rstWaitWait", s, E_MEMB);
        s = '0; s.rst = 1;
        applyStimulus("rstWaitHold", s, E_MEMB);
        s = '0;
        applyStimulus("rstWaitCleared", s, E_IDLE);

        // Timeout: four wait cycles with no ready, then sticky ERROR.
        s = '0; s.memReq = 1;
        applyStimulus("toReq", s, E_MEMR);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("toWait%0d", i), s, E_MEMB);
        end
        applyStimulus("toError", s, E_ERR);
        s = '0; s.ready = 1; s.branch = 1;
        applyStimulus("toErrorSticky", s, E_ERR);
        s = '0; s.rst = 1;
        applyStimulus("toRstCycle", s, E_ERR);
        s = '0;
        applyStimulus("toCleared", s, E_IDLE);
        s = '0; s.fwd = 1; s.exeMemRead = 1; s.exeDest = 9; s.exeWb = 1; s.two = 1; s.src2 = 9;
        applyStimulus("postResetHazard", s, E_STALL);

        repeat (3) @(posedge clk);
        checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
